// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU micro-step sequencers: step encoding,
// ALU function codes and default parameter values.
package alu_ctrl_pkg;

    // One-hot step encoding; IDLE is the all-zero pattern.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        OP1  = 4'd1,
        OP2  = 4'd2,
        WB   = 4'd4,
        FIN  = 4'd8
    } step_e;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam int DEF_REG_ADDR_W        = 5;
    localparam int DEF_ALU_SEL_W         = 3;
    localparam int DEF_STEP_W            = 6;
    localparam bit DEF_SUPPRESS_X0_WRITE = 1'b1;

endpackage

// File: rtl/step_counter.sv
// One-hot step register shared by the instruction sequencers.
// clear has priority over load_first, which has priority over advance;
// with none asserted the current step is held.
module step_counter #(
    parameter int STEP_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_first,
    input  logic              advance,
    input  logic              clear,
    output logic [STEP_W-1:0] step
);

    // Step register: clear to idle, load the first step, or shift to the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
        end else if (clear) begin
            step <= '0;
        end else if (load_first) begin
            step <= STEP_W'(1);
        end else if (advance) begin
            step <= step << 1;
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Micro-step sequencer for reg/reg and reg/imm ALU instructions.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new instruction; all enables low
// OP1   | read rs1 into ALU operand latch 1
// OP2   | read rs2 (or route the immediate) into ALU operand latch 2
// WB    | drive ALU result and write it to rd (skipped for x0 if enabled)
// FIN   | one-cycle done pulse, then back to IDLE
//
// hold freezes any non-idle step and masks every enable and done.
module alu_instr_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
    parameter int ALU_SEL_W         = DEF_ALU_SEL_W,
    parameter int STEP_W            = DEF_STEP_W,
    parameter bit SUPPRESS_X0_WRITE = DEF_SUPPRESS_X0_WRITE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ready,
    input  logic                  is_imm,
    input  logic [ALU_SEL_W-1:0]  alu_sel_in,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  hold,
    output logic [REG_ADDR_W-1:0] reg_index,
    output logic                  reg_r_en,
    output logic                  reg_w_en,
    output logic                  alu1_w_en,
    output logic                  alu2_w_en,
    output logic                  alu0_r_en,
    output logic                  imm_en,
    output logic [ALU_SEL_W-1:0]  alu_function_sel,
    output logic [STEP_W-1:0]     step,
    output logic                  done
);

    localparam logic [STEP_W-1:0] LOW_MASK = STEP_W'(4'hF);

    logic [STEP_W-1:0]     step_q;
    logic                  load_first;
    logic                  advance;
    logic                  clear;
    logic                  illegal;
    step_e                 state;

    logic                  is_imm_q;
    logic [ALU_SEL_W-1:0]  alu_sel_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;

    step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_first (load_first),
        .advance    (advance),
        .clear      (clear),
        .step       (step_q)
    );

    // Reserved upper bits set means the register was corrupted.
    assign illegal = (step_q & ~LOW_MASK) != '0;
    assign state   = step_e'(step_q[3:0]);
    assign step    = step_q & LOW_MASK;

    // Capture the instruction fields only on the accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_imm_q  <= 1'b0;
            alu_sel_q <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else if (load_first) begin
            is_imm_q  <= is_imm;
            alu_sel_q <= alu_sel_in;
            rd_q      <= rd;
            rs1_q     <= rs1;
            rs2_q     <= rs2;
        end
    end

    // Next-step control and output decode from the current step.
    always_comb begin
        ready            = 1'b0;
        load_first       = 1'b0;
        advance          = 1'b0;
        clear            = 1'b0;
        reg_index        = '0;
        reg_r_en         = 1'b0;
        reg_w_en         = 1'b0;
        alu1_w_en        = 1'b0;
        alu2_w_en        = 1'b0;
        alu0_r_en        = 1'b0;
        imm_en           = 1'b0;
        alu_function_sel = '0;
        done             = 1'b0;

        if (illegal) begin
            clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ready      = 1'b1;
                    load_first = start;
                end
                OP1: begin
                    alu_function_sel = alu_sel_q;
                    if (!hold) begin
                        advance   = 1'b1;
                        reg_index = rs1_q;
                        reg_r_en  = 1'b1;
                        alu1_w_en = 1'b1;
                    end
                end
                OP2: begin
                    alu_function_sel = alu_sel_q;
                    if (!hold) begin
                        advance   = 1'b1;
                        alu2_w_en = 1'b1;
                        if (is_imm_q) begin
                            imm_en = 1'b1;
                        end else begin
                            reg_index = rs2_q;
                            reg_r_en  = 1'b1;
                        end
                    end
                end
                WB: begin
                    alu_function_sel = alu_sel_q;
                    if (!hold) begin
                        advance   = 1'b1;
                        reg_index = rd_q;
                        alu0_r_en = 1'b1;
                        reg_w_en  = !(SUPPRESS_X0_WRITE && (rd_q == '0));
                    end
                end
                FIN: begin
                    alu_function_sel = alu_sel_q;
                    if (!hold) begin
                        clear = 1'b1;
                        done  = 1'b1;
                    end
                end
                default: clear = 1'b1;
            endcase
        end
    end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Parametrised micro-step sequencer for register/register and register/immediate ALU instructions; replaces the per-opcode combinational control blocks with one clocked block.
- Sits between the instruction decoder and the register file / ALU operand latches.
- Accepts one decoded instruction per handshake, walks a one-hot step counter, drives register-file and ALU latch enables, and pulses done.
- Idle outputs drive 0, never Z.

Parameters:
- REG_ADDR_W, 5, register index width.
- ALU_SEL_W, 3, ALU function-select width.
- STEP_W, 6, one-hot step-counter width; must be >= 4.
- SUPPRESS_X0_WRITE, 1, when 1 a write to register index 0 is skipped (reg_w_en stays 0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  decoder offers an instruction.
- ready  out  1  high only in IDLE; a transfer occurs when start && ready.
- is_imm  in  1  1 = immediate form (second operand from immediate path).
- alu_sel_in  in  ALU_SEL_W  ALU function for this instruction.
- rd, rs1, rs2  in  REG_ADDR_W each  register indices.
- hold  in  1  stall request from the datapath.
- reg_index  out  REG_ADDR_W  register-file index.
- reg_r_en, reg_w_en  out  1 each  register-file read/write enables.
- alu1_w_en, alu2_w_en  out  1 each  ALU operand latch enables.
- alu0_r_en  out  1  ALU result drive enable.
- imm_en  out  1  immediate onto operand-2 bus.
- alu_function_sel  out  ALU_SEL_W  latched ALU function.
- step  out  STEP_W  one-hot current step; all-zero in IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except ready=1; latched fields cleared. A reset mid-instruction abandons it with no write and no done.
- On transfer: latch is_imm, alu_sel_in, rd, rs1, rs2. Next cycle enters OP1. Inputs are ignored outside the transfer cycle.
- States and outputs (all enables are 0 unless listed):
  - IDLE: step=0. Moves to OP1 on transfer.
  - OP1: step bit0; reg_index=rs1, reg_r_en=1, alu1_w_en=1. Moves to OP2.
  - OP2: step bit1. If is_imm: imm_en=1, alu2_w_en=1, reg_index=0. Else: reg_index=rs2, reg_r_en=1, alu2_w_en=1. Moves to WB.
  - WB: step bit2; reg_index=rd, alu0_r_en=1. reg_w_en=1 unless SUPPRESS_X0_WRITE && rd==0. Moves to FIN.
  - FIN: step bit3; done=1. Moves to IDLE.
- alu_function_sel holds the latched value in OP1..FIN and is 0 in IDLE.
- Latency: transfer at cycle T gives done at T+4 with no hold; the next transfer is possible at T+5.
- ready is 0 in every non-IDLE state, so start during FIN is not accepted.
- hold=1 in OP1..FIN: state frozen, step held, all enables and done forced 0. Resumes the same step on the first cycle with hold=0, so there are no duplicate enables and no lost steps.
- hold in IDLE is ignored; a transfer still occurs.
- Step bits above bit3 are reserved for future multi-cycle ops and are always 0.
- Any illegal or unreachable state recovers to IDLE on the next clock.

Decomposition:
- Shared package (alu_ctrl_pkg):
  - step enum: IDLE=0, OP1=1, OP2=2, WB=4, FIN=8, one-hot within STEP_W.
  - ALU function codes (ADD=3'b001, ...).
  - Default parameter constants.
- One sub-module, step_counter: one-hot shift register with advance/hold/clear, shared with future load/store sequencers.
- Output decode stays in the top module.

Test Plan:
- Reset then R-type add (rs1=3, rs2=7, rd=9, alu_sel=001) with start held 1 cycle -> ready drops at T+1; reg_index 3/7/9 at T+1/T+2/T+3; reg_w_en=1 at T+3; done=1 at T+4 only; ready=1 at T+5.
- Immediate form (is_imm=1, rs1=5, rd=6) -> at T+2 imm_en=1, alu2_w_en=1, reg_r_en=0; write to 6 at T+3.
- rd=0 with SUPPRESS_X0_WRITE=1 -> WB cycle shows alu0_r_en=1, reg_w_en=0; done still at T+4. With the parameter set to 0, reg_w_en=1.
- hold=1 for 2 cycles entering WB -> step=4 held, reg_w_en=0 during hold; exactly one reg_w_en pulse after release; done at T+6.
- rst_n low asynchronously mid-OP2 -> all enables 0 immediately, ready=1, no done. A new transfer after release runs normally.
- start held high continuously -> instructions accepted every 5 cycles; no acceptance while ready=0; Z never appears on any output.
